// File: rtl/addsub_sequencer_if.sv
// Handshake bundle for addsub_sequencer: an operand channel (in_*, a, b, mode)
// and a result channel (out_*, s, cout, ovf, zero).
// The slave modport is the sequencer; the master modport is its producer/consumer.
interface addsub_sequencer_if #(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;
  logic         zero;

  modport master (
    output in_valid,
    input  in_ready,
    output a,
    output b,
    output mode,
    input  out_valid,
    output out_ready,
    input  s,
    input  cout,
    input  ovf,
    input  zero
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  a,
    input  b,
    input  mode,
    output out_valid,
    input  out_ready,
    output s,
    output cout,
    output ovf,
    output zero
  );
endinterface

// File: rtl/addsub_sequencer.sv
// addsub_sequencer: wide add/subtract walked one nibble per clock through a
// 4-bit ripple slice of full-adder cells, with the inter-nibble carry held in a
// register. Operands arrive and results leave over valid/ready handshakes.
//
// Optional feature macro: ADDSUB_SEQ_FLAGS_EN
//   defined   -> ovf (signed overflow) and zero flags computed and registered
//   undefined -> flag logic removed, ovf and zero tied to 0
module addsub_sequencer #(
  parameter int unsigned NIBBLES = 4
) (
  input logic              clk,
  input logic              rst,
  addsub_sequencer_if.slave bus
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned CntW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            mode_q, mode_d;
  logic [W-1:0]    s_q, s_d;
  logic            cout_q, cout_d;
`ifdef ADDSUB_SEQ_FLAGS_EN
  logic            ovf_q, ovf_d;
  logic            zero_q, zero_d;
`endif

  // 4-bit slice: b is inverted for subtract; carry_q seeds it (mode on the first nibble).
  logic [3:0] slice_a;
  logic [3:0] slice_b;
  logic [3:0] slice_sum;
  logic [4:0] slice_c;

  assign slice_a    = a_q[4*cnt_q +: 4];
  assign slice_b    = b_q[4*cnt_q +: 4] ^ {4{mode_q}};
  assign slice_c[0] = carry_q;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign slice_sum[i]   = slice_a[i] ^ slice_b[i] ^ slice_c[i];
    assign slice_c[i + 1] = (slice_a[i] & slice_b[i]) |
                            (slice_c[i] & (slice_a[i] ^ slice_b[i]));
  end

  // State and datapath registers, all cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
`ifdef ADDSUB_SEQ_FLAGS_EN
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
`ifdef ADDSUB_SEQ_FLAGS_EN
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
`endif
    end
  end

  // Next-state and datapath update: latch in IDLE, one nibble per CALC cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    s_d     = s_q;
    cout_d  = cout_q;
`ifdef ADDSUB_SEQ_FLAGS_EN
    ovf_d   = ovf_q;
    zero_d  = zero_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          mode_d  = bus.mode;
          cnt_d   = '0;
          carry_d = bus.mode;
          state_d = StCalc;
        end
      end
      StCalc: begin
        s_d[4*cnt_q +: 4] = slice_sum;
        carry_d           = slice_c[4];
        cnt_d             = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          cout_d  = slice_c[4];
`ifdef ADDSUB_SEQ_FLAGS_EN
          // Overflow when carries into and out of the sign bit disagree.
          ovf_d   = slice_c[3] ^ slice_c[4];
          zero_d  = (s_d == '0);
`endif
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Handshake outputs decode only registered state.
  always_comb begin
    bus.in_ready  = (state_q == StIdle);
    bus.out_valid = (state_q == StDone);
    bus.s         = s_q;
    bus.cout      = cout_q;
`ifdef ADDSUB_SEQ_FLAGS_EN
    bus.ovf       = ovf_q;
    bus.zero      = zero_q;
`else
    bus.ovf       = 1'b0;
    bus.zero      = 1'b0;
`endif
  end

endmodule

// File: tb/tb_addsub_sequencer.sv
// Self-checking bench for addsub_sequencer (NIBBLES = 4): directed spec cases
// plus randomized operations scored against an arithmetic reference model.
module tb_addsub_sequencer;

  localparam int unsigned N = 4;
  localparam int unsigned W = 4 * N;
`ifdef ADDSUB_SEQ_FLAGS_EN
  localparam bit FlagsEn = 1'b1;
`else
  localparam bit FlagsEn = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  addsub_sequencer_if #(.NIBBLES(N)) bus ();

  addsub_sequencer #(.NIBBLES(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // Reference: plain wide arithmetic, unsigned carry/borrow, signed range test.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                input logic mm, output logic [W-1:0] ms,
                                output logic mc, output logic mo, output logic mz);
    longint sa, sb, r, hi, lo;
    sa = ma[W-1] ? longint'(ma) - (longint'(1) << W) : longint'(ma);
    sb = mb[W-1] ? longint'(mb) - (longint'(1) << W) : longint'(mb);
    if (!mm) begin
      ms = ma + mb;
      mc = (longint'(ma) + longint'(mb)) >= (longint'(1) << W);
      r  = sa + sb;
    end else begin
      ms = ma - mb;
      mc = (ma >= mb);
      r  = sa - sb;
    end
    hi = (longint'(1) << (W - 1)) - 1;
    lo = -(longint'(1) << (W - 1));
    mo = FlagsEn && ((r > hi) || (r < lo));
    mz = FlagsEn && (ms == '0);
  endfunction

  // Wait for in_ready, present operands for one edge, then count cycles to out_valid.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic im,
                       output int lat);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    bus.in_valid = 1'b1;
    bus.a        = ia;
    bus.b        = ib;
    bus.mode     = im;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.s, bus.cout, bus.ovf, bus.zero} !==
        {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: got rdy=%b vld=%b s=%h c=%b o=%b z=%b required 1 0 0000 0 0 0",
               bus.in_ready, bus.out_valid, bus.s, bus.cout, bus.ovf, bus.zero);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    int lat;
    issue(16'h1234, 16'h0FFF, 1'b0, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL add_latency: got %0d required 4", lat);
    end
    checks++;
    if ({bus.s, bus.cout, bus.ovf, bus.zero} !== {16'h2233, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL add_result: got s=%h c=%b o=%b z=%b required s=2233 c=0 o=0 z=0",
               bus.s, bus.cout, bus.ovf, bus.zero);
    end
    release_result();
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL add_return_idle: got rdy=%b vld=%b required rdy=1 vld=0",
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_sub();
    int lat;
    issue(16'h0005, 16'h0007, 1'b1, lat);
    checks++;
    if ({bus.s, bus.cout, bus.ovf} !== {16'hFFFE, 1'b0, 1'b0} || lat !== 4) begin
      errors++;
      $display("FAIL sub_borrow: got s=%h c=%b o=%b lat=%0d required s=fffe c=0 o=0 lat=4",
               bus.s, bus.cout, bus.ovf, lat);
    end
    release_result();
    issue(16'h1234, 16'h1234, 1'b1, lat);
    checks++;
    if ({bus.s, bus.cout, bus.zero} !== {16'h0000, 1'b1, FlagsEn}) begin
      errors++;
      $display("FAIL sub_equal: got s=%h c=%b z=%b required s=0000 c=1 z=%b",
               bus.s, bus.cout, bus.zero, FlagsEn);
    end
    release_result();
  endtask

  task automatic test_overflow();
    int lat;
    issue(16'h7FFF, 16'h0001, 1'b0, lat);
    checks++;
    if ({bus.s, bus.cout, bus.ovf, bus.zero} !== {16'h8000, 1'b0, FlagsEn, 1'b0}) begin
      errors++;
      $display("FAIL signed_ovf: got s=%h c=%b o=%b z=%b required s=8000 c=0 o=%b z=0",
               bus.s, bus.cout, bus.ovf, bus.zero, FlagsEn);
    end
    release_result();
    issue(16'hFFFF, 16'h0001, 1'b0, lat);
    checks++;
    if ({bus.s, bus.cout, bus.ovf, bus.zero} !== {16'h0000, 1'b1, 1'b0, FlagsEn}) begin
      errors++;
      $display("FAIL carry_chain: got s=%h c=%b o=%b z=%b required s=0000 c=1 o=0 z=%b",
               bus.s, bus.cout, bus.ovf, bus.zero, FlagsEn);
    end
    release_result();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [W+2:0] held;
    issue(16'hA5A5, 16'h1111, 1'b1, lat);
    held = {bus.s, bus.cout, bus.ovf, bus.zero};
    checks++;
    if (lat !== 4 || bus.s !== 16'h9494) begin
      errors++;
      $display("FAIL bp_result: got s=%h lat=%0d required s=9494 lat=4", bus.s, lat);
    end
    // Offer a competing operand set while the result is stalled.
    bus.in_valid = 1'b1;
    bus.a        = 16'h0003;
    bus.b        = 16'h0004;
    bus.mode     = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.out_valid, bus.in_ready} !== 2'b10 ||
          {bus.s, bus.cout, bus.ovf, bus.zero} !== held) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b s=%h required vld=1 rdy=0 s=%h",
                 k, bus.out_valid, bus.in_ready, bus.s, held[W+2:3]);
      end
    end
    bus.in_valid = 1'b0;
    release_result();
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL bp_release: got rdy=%b vld=%b required rdy=1 vld=0",
               bus.in_ready, bus.out_valid);
    end
    repeat (6) begin
      @(posedge clk); #1;
    end
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL bp_no_accept: got rdy=%b vld=%b required rdy=1 vld=0",
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_reset_mid_calc();
    int lat;
    int seen;
    bus.in_valid = 1'b1;
    bus.a        = 16'h1111;
    bus.b        = 16'h2222;
    bus.mode     = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.s, bus.cout} !== {1'b1, 1'b0, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: got rdy=%b vld=%b s=%h c=%b required 1 0 0000 0",
               bus.in_ready, bus.out_valid, bus.s, bus.cout);
    end
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL mid_reset_no_result: got %0d valid cycles required 0", seen);
    end
    issue(16'h0001, 16'h0001, 1'b0, lat);
    checks++;
    if (bus.s !== 16'h0002 || lat !== 4) begin
      errors++;
      $display("FAIL after_reset_op: got s=%h lat=%0d required s=0002 lat=4", bus.s, lat);
    end
    release_result();
  endtask

  task automatic test_random();
    int lat;
    logic [W-1:0] ra, rb, es;
    logic rm, ec, eo, ez;
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rm = 1'($urandom_range(0, 1));
      if (n % 8 == 0) rb = ra;
      model(ra, rb, rm, es, ec, eo, ez);
      issue(ra, rb, rm, lat);
      checks++;
      if ({bus.s, bus.cout, bus.ovf, bus.zero} !== {es, ec, eo, ez} || lat !== 4) begin
        errors++;
        $display("FAIL random[%0d] %h %s %h: got s=%h c=%b o=%b z=%b lat=%0d required s=%h c=%b o=%b z=%b lat=4",
                 n, ra, rm ? "-" : "+", rb, bus.s, bus.cout, bus.ovf, bus.zero, lat,
                 es, ec, eo, ez);
      end
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      release_result();
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int hits[$];
    logic [W-1:0] es;
    logic ec, eo, ez;
    model(16'h4321, 16'h8765, 1'b1, es, ec, eo, ez);
    bus.in_valid  = 1'b1;
    bus.a         = 16'h4321;
    bus.b         = 16'h8765;
    bus.mode      = 1'b1;
    bus.out_ready = 1'b1;
    cyc = 0;
    for (int k = 0; k < 22; k++) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.out_valid) begin
        hits.push_back(cyc);
        checks++;
        if ({bus.s, bus.cout, bus.ovf, bus.zero} !== {es, ec, eo, ez}) begin
          errors++;
          $display("FAIL b2b_result: got s=%h c=%b required s=%h c=%b",
                   bus.s, bus.cout, es, ec);
        end
      end
    end
    bus.in_valid = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
    checks++;
    if (hits.size() < 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d results required at least 3", hits.size());
    end else if (hits[1] - hits[0] !== N + 2 || hits[2] - hits[1] !== N + 2) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d,%0d cycles required %0d", hits[1] - hits[0],
               hits[2] - hits[1], N + 2);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.mode      = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_backpressure();
    test_reset_mid_calc();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
